// File: rtl/video_mode_pkg.sv
// video_mode_ctrl shared types: FSM states, scanline levels, watchdog width.
// Optional OSD timer is enabled with VMODE_OSD_TIMER_EN.
package video_mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BLANK_PRE  = 2'd1,
    ST_BLANK_HOLD = 2'd2,
    ST_RST_HOLD   = 2'd3
  } vmode_state_t;

  typedef logic [1:0] scanline_t;

  localparam scanline_t SL_OFF = 2'd0;
  localparam scanline_t SL_25  = 2'd1;
  localparam scanline_t SL_50  = 2'd2;
  localparam scanline_t SL_75  = 2'd3;

  localparam int WDOG_BITS = 21;

endpackage

// File: rtl/video_mode_ctrl_if.sv
// Hotkey request / video control bundle between keyboard, core and ctrl.
// osd_show exists only when VMODE_OSD_TIMER_EN is defined.
interface video_mode_ctrl_if;
  import video_mode_pkg::*;

  logic      req_scandbl;
  logic      req_scanlines;
  logic      req_reset;
  logic      vsync;
  logic      scandoubler_disable;
  scanline_t scanlines;
  logic      video_blank;
  logic      core_reset;
  logic      busy;
`ifdef VMODE_OSD_TIMER_EN
  logic      osd_show;
`endif

  modport master (
    output req_scandbl,
    output req_scanlines,
    output req_reset,
    output vsync,
    input  scandoubler_disable,
    input  scanlines,
    input  video_blank,
    input  core_reset,
`ifdef VMODE_OSD_TIMER_EN
    input  osd_show,
`endif
    input  busy
  );

  modport slave (
    input  req_scandbl,
    input  req_scanlines,
    input  req_reset,
    input  vsync,
    output scandoubler_disable,
    output scanlines,
    output video_blank,
    output core_reset,
`ifdef VMODE_OSD_TIMER_EN
    output osd_show,
`endif
    output busy
  );

endinterface

// File: rtl/req_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse.
// Pulse is high for one cycle, three cycles after d rises.
module req_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], d};
      pulse <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Hotkey-driven scan-rate / scanline / core-reset sequencer (clk_sys).
// Define VMODE_OSD_TIMER_EN to add the osd_show frame timer.
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int BLANK_FRAMES = 4,
  parameter int RESET_CYCLES = 1024,
  parameter bit INIT_15K     = 1'b0,
  parameter int WDOG_W       = WDOG_BITS
) (
  input logic              clk_sys,
  input logic              reset,
  video_mode_ctrl_if.slave vm
);

  localparam int RC_W = $clog2(RESET_CYCLES);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] PRE  = ST_BLANK_PRE;
  localparam logic [1:0] HOLD = ST_BLANK_HOLD;
  localparam logic [1:0] RST  = ST_RST_HOLD;

  logic              ev_rst;
  logic              ev_sdb;
  logic              ev_sl;
  logic              vs_q;
  logic              vs_rise;
  logic [1:0]        state;
  logic [1:0]        state_n;
  logic              sd;
  scanline_t         sl;
  logic              blank;
  logic              crst;
  logic              busy;
  logic [3:0]        fcnt;
  logic [RC_W-1:0]   rcnt;
  logic [WDOG_W-1:0] wcnt;
  logic              last_frame;
  logic              rc_done;
  logic              wd_exp;
  logic              wd_run;
  logic              toggle;
  logic              sl_step;

  req_sync_edge u_sync_rst (
    .clk   (clk_sys),
    .rst   (reset),
    .d     (vm.req_reset),
    .pulse (ev_rst)
  );

  req_sync_edge u_sync_sdb (
    .clk   (clk_sys),
    .rst   (reset),
    .d     (vm.req_scandbl),
    .pulse (ev_sdb)
  );

  req_sync_edge u_sync_sl (
    .clk   (clk_sys),
    .rst   (reset),
    .d     (vm.req_scanlines),
    .pulse (ev_sl)
  );

  assign vs_rise    = vm.vsync & ~vs_q;
  assign last_frame = fcnt == 4'(BLANK_FRAMES - 1);
  assign rc_done    = rcnt == RC_W'(RESET_CYCLES - 1);
  assign wd_exp     = (wcnt == '1) & ~vs_rise;

  always_comb begin
    state_n = state;
    toggle  = 1'b0;
    sl_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev_rst)      state_n = RST;
        else if (ev_sdb) state_n = PRE;
        else             sl_step = ev_sl & ~sd;
      end
      PRE: begin
        if (ev_rst) begin
          state_n = RST;
        end else if (vs_rise) begin
          state_n = HOLD;
          toggle  = 1'b1;
        end else if (wd_exp) begin
          state_n = IDLE;
          toggle  = 1'b1;
        end
      end
      HOLD: begin
        if (ev_rst)
          state_n = RST;
        else if ((vs_rise && last_frame) || wd_exp)
          state_n = IDLE;
      end
      RST: begin
        if (!ev_rst && rc_done) state_n = IDLE;
      end
    endcase
  end

  // Watchdog restarts on every state change and every vsync edge
  assign wd_run = (state_n == PRE || state_n == HOLD) &&
                  (state_n == state) && !vs_rise;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      vs_q  <= 1'b0;
      sd    <= INIT_15K;
      sl    <= SL_OFF;
      blank <= 1'b0;
      crst  <= 1'b0;
      busy  <= 1'b0;
      fcnt  <= '0;
      rcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      vs_q  <= vm.vsync;
      busy  <= state_n != IDLE;
      blank <= state_n != IDLE;
      crst  <= state_n == RST;
      if (toggle)  sd <= ~sd;
      if (sl_step) sl <= sl + 2'd1;
      if (state != HOLD || state_n != HOLD)
        fcnt <= '0;
      else if (vs_rise)
        fcnt <= fcnt + 4'd1;
      if (ev_rst || state_n != RST)
        rcnt <= '0;
      else
        rcnt <= rcnt + RC_W'(1);
      if (wd_run) wcnt <= wcnt + WDOG_W'(1);
      else        wcnt <= '0;
    end
  end

`ifdef VMODE_OSD_TIMER_EN
  logic       osd;
  logic [6:0] ocnt;
  logic       osd_hit;

  assign osd_hit = (state == IDLE) && !ev_rst &&
                   (ev_sdb || (ev_sl && !sd));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      osd  <= 1'b0;
      ocnt <= '0;
    end else if (osd_hit) begin
      osd  <= 1'b1;
      ocnt <= '0;
    end else if (osd && vs_rise) begin
      if (ocnt == 7'd119) osd <= 1'b0;
      else                ocnt <= ocnt + 7'd1;
    end
  end

  assign vm.osd_show = osd;
`endif

  assign vm.scandoubler_disable = sd;
  assign vm.scanlines           = sl;
  assign vm.video_blank         = blank;
  assign vm.core_reset          = crst;
  assign vm.busy                = busy;

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Sequences the user-selectable video and reset controls of an arcade core top level from hotkey request lines driven by the PS/2 keyboard translator.
- Synchronises and edge-detects the requests, then holds the scandoubler-disable and scanline-level registers.
- Forces a blanking window of whole frames around a scan-rate change so the monitor re-locks cleanly.
- Stretches the reset hotkey into a fixed-length core reset. It sits between the keyboard translator and the video/core blocks, in the clk_sys domain.

Parameters:
- BLANK_FRAMES, 4, number of vsync frames video is held blanked after a scan-rate change (1..15).
- RESET_CYCLES, 1024, length in clk_sys cycles of the core reset pulse (>=16).
- INIT_15K, 0, reset value of scandoubler_disable (0 = 31 kHz VGA, 1 = 15 kHz).

Ports:
- clk_sys  in  1  system clock (24.576 MHz).
- reset  in  1  synchronous active-high reset.
- req_scandbl  in  1  scan-rate toggle request, level, asynchronous to clk_sys.
- req_scanlines  in  1  scanline-level step request, level, asynchronous.
- req_reset  in  1  core reset request, level, asynchronous.
- vsync  in  1  core vertical sync, active high, clk_sys domain.
- scandoubler_disable  out  1  1 = 15 kHz passthrough.
- scanlines  out  2  scanline level: 0 off, 1 = 25%, 2 = 50%, 3 = 75%.
- video_blank  out  1  force video output black.
- core_reset  out  1  active-high reset to the game core.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: scandoubler_disable=INIT_15K; scanlines=0; video_blank=0; core_reset=0; busy=0; FSM=IDLE; all counters 0.
- Request inputs:
  - Each passes a 2-flop synchroniser followed by a rising-edge detector.
  - An event is a one-cycle pulse 3 cycles after the input rises.
  - No clock is ever derived from a request line.
- vsync: the rising edge is detected with one register; no synchroniser.
- FSM states: IDLE, BLANK_PRE, BLANK_HOLD, RST_HOLD.
- IDLE, event priority: reset > scandbl > scanlines. Only one event is accepted per cycle; the lower-priority events in that cycle are dropped.
  - reset event -> RST_HOLD. core_reset=1 and video_blank=1 from the next cycle.
  - scandbl event -> BLANK_PRE. video_blank=1 from the next cycle.
  - scanlines event -> scanlines increments by 1 mod 4 (3 -> 0) the next cycle; stays in IDLE.
    - The event is ignored while scandoubler_disable=1, where scanlines hold their value.
- BLANK_PRE: waits for the first vsync rising edge, then toggles scandoubler_disable on that cycle, clears the frame counter and moves to BLANK_HOLD.
- BLANK_HOLD: counts vsync rising edges. When the count reaches BLANK_FRAMES, returns to IDLE and video_blank=0 the next cycle.
- RST_HOLD: a cycle counter runs. core_reset drops after exactly RESET_CYCLES cycles high, then video_blank drops and the FSM returns to IDLE.
- Events outside IDLE:
  - Events arriving while not in IDLE are discarded, except a reset event during BLANK_PRE/BLANK_HOLD.
  - That reset event aborts the blank sequence and enters RST_HOLD.
  - If BLANK_PRE had not yet toggled, scandoubler_disable stays unchanged.
- A reset event during RST_HOLD restarts the cycle counter (the pulse is extended).
- busy = (FSM != IDLE), registered.
- Missing vsync: if no vsync edge arrives within 2^21 cycles in BLANK_PRE or BLANK_HOLD, a watchdog forces the pending toggle (if still pending) and returns to IDLE.
- Reset asserted mid-operation: every output returns to its reset value on the next edge. scandoubler_disable returns to INIT_15K, not to its previous value.

Optional Feature:
- Macro: VMODE_OSD_TIMER_EN.
- With the macro:
  - Adds output osd_show (1 bit, reset 0).
  - osd_show goes high the cycle after any accepted scandbl or scanlines event.
  - It stays high for 120 vsync rising edges; a new accepted event restarts the count.
- Without the macro: the port and its 7-bit frame counter are absent.

Decomposition:
- Package video_mode_pkg holds:
  - the FSM state enum vmode_state_t;
  - the scanline level typedef scanline_t (2-bit) and its constants SL_OFF, SL_25, SL_50, SL_75;
  - WDOG_BITS = 21.
- Sub-module req_sync_edge: 2-flop synchroniser plus rising-edge pulse, instantiated three times.

Test Plan:
- Reset, then raise req_scanlines with INIT_15K=0 -> scanlines 0->1 exactly 4 cycles after the rise; three more presses -> 2, 3, 0.
- req_scandbl, vsync period 1000 cycles, BLANK_FRAMES=4 -> video_blank=1 at +4 cycles; scandoubler_disable toggles at the first vsync edge; video_blank=0 one cycle after the 5th vsync edge from entry.
- req_reset with RESET_CYCLES=1024 -> core_reset high for exactly 1024 cycles, video_blank falls on the same cycle; busy mirrors the hold.
- Simultaneous rise of req_reset and req_scandbl -> only RST_HOLD entered; scandoubler_disable unchanged.
- req_scanlines while scandoubler_disable=1 -> scanlines unchanged; req_scandbl with vsync tied low -> toggle forced after 2^21 cycles, FSM back to IDLE.
- Reset asserted mid-BLANK_HOLD -> next cycle: video_blank=0, busy=0, scandoubler_disable=INIT_15K, scanlines=0.
